// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - instruction FIFO and issue sequencer in front of a shared combinational ALU
// Each instruction is issued, given ALU_LAT cycles to settle, captured, and held until the consumer takes it.
module alu_op_sequencer #(
  parameter int DATA_W  = 8,
  parameter int OPC_W   = 3,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opc,
  input  logic [DATA_W-1:0] in_op_a,
  input  logic [DATA_W-1:0] in_op_b,
  input  logic              in_use_acc,
  input  logic              in_clr_acc,
  output logic [OPC_W-1:0]  alu_opc,
  output logic [DATA_W-1:0] alu_op_a,
  output logic [DATA_W-1:0] alu_op_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef struct packed {
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              use_acc;
    logic              clr_acc;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            cur_q, cur_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [OPC_W-1:0]  alu_opc_q, alu_opc_d;
  logic [DATA_W-1:0] alu_op_a_q, alu_op_a_d;
  logic [DATA_W-1:0] alu_op_b_q, alu_op_b_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  state_t            state_q, state_d;

  logic   push;
  logic   pop;
  logic   fifo_nempty;
  logic   do_issue;
  logic   do_capture;
  logic   do_accept;
  entry_t in_entry;

  assign fifo_nempty = (count_q != '0);
  assign in_ready    = (count_q != CNT_W'(DEPTH));
  assign push        = in_valid && in_ready;
  assign in_entry    = '{opc: in_opc, op_a: in_op_a, op_b: in_op_b,
                         use_acc: in_use_acc, clr_acc: in_clr_acc};

  // Storage carries no reset; occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (fifo_nempty) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (wait_q == '0) state_d = S_DONE;
      S_DONE:  if (res_ready) state_d = fifo_nempty ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    do_accept  = 1'b0;
    case (state_q)
      S_IDLE:  pop = fifo_nempty;
      S_ISSUE: do_issue = 1'b1;
      S_WAIT:  do_capture = (wait_q == '0);
      S_DONE: begin
        do_accept = res_ready;
        pop       = res_ready && fifo_nempty;
      end
      default: pop = 1'b0;
    endcase
  end

  // Accumulator update reads cur_q before a same-cycle pop replaces it.
  always_comb begin
    cur_d       = cur_q;
    acc_d       = acc_q;
    wait_d      = wait_q;
    alu_opc_d   = alu_opc_q;
    alu_op_a_d  = alu_op_a_q;
    alu_op_b_d  = alu_op_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    if (pop) begin
      cur_d = mem_q[rd_ptr_q];
    end
    if (do_issue) begin
      alu_opc_d  = cur_q.opc;
      alu_op_a_d = cur_q.use_acc ? acc_q : cur_q.op_a;
      alu_op_b_d = cur_q.op_b;
      wait_d     = WAIT_W'(ALU_LAT - 1);
    end
    if (state_q == S_WAIT && wait_q != '0) begin
      wait_d = wait_q - WAIT_W'(1);
    end
    if (do_capture) begin
      res_data_d  = alu_result;
      res_valid_d = 1'b1;
    end
    if (do_accept) begin
      res_valid_d = 1'b0;
      acc_d       = cur_q.clr_acc ? '0 : res_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cur_q       <= '0;
      acc_q       <= '0;
      wait_q      <= '0;
      alu_opc_q   <= '0;
      alu_op_a_q  <= '0;
      alu_op_b_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cur_q       <= cur_d;
      acc_q       <= acc_d;
      wait_q      <= wait_d;
      alu_opc_q   <= alu_opc_d;
      alu_op_a_q  <= alu_op_a_d;
      alu_op_b_q  <= alu_op_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign alu_opc   = alu_opc_q;
  assign alu_op_a  = alu_op_a_q;
  assign alu_op_b  = alu_op_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != S_IDLE) || fifo_nempty;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - scoreboard bench for alu_op_sequencer with an ALU stub
// Expected results come from an in-order reference model evaluated when each instruction is accepted.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opc;
  logic [7:0] in_op_a;
  logic [7:0] in_op_b;
  logic       in_use_acc;
  logic       in_clr_acc;
  logic [2:0] alu_opc;
  logic [7:0] alu_op_a;
  logic [7:0] alu_op_b;
  logic [7:0] alu_result;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       busy;

  logic rand_rdy;
  logic rr_main;
  logic rr_rand;
  assign res_ready = rand_rdy ? rr_rand : rr_main;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  alu_op_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opc(in_opc), .in_op_a(in_op_a), .in_op_b(in_op_b),
    .in_use_acc(in_use_acc), .in_clr_acc(in_clr_acc),
    .alu_opc(alu_opc), .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  // ALU stub: 0 add, 1 sub, 2 and, 3 or, 4 xor, others pass A.
  function automatic logic [7:0] alu_stub(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    case (o)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction
  assign alu_result = alu_stub(alu_opc, alu_op_a, alu_op_b);

  function automatic int ref_op(input int o, input int a, input int b);
    case (o)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      default: return a;
    endcase
  endfunction

  typedef struct {
    logic [2:0] opc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int         model_acc = 0;
  int         accepted = 0;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", nm, act, act, req, req);
  endtask

  always @(negedge clk) begin
    int   ea;
    int   r;
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      ea    = in_use_acc ? model_acc : int'($signed(in_op_a));
      r     = ref_op(int'(in_opc), ea, int'($signed(in_op_b)));
      e.opc = in_opc;
      e.a   = 8'(ea);
      e.b   = in_op_b;
      e.res = 8'(r);
      exp_q.push_back(e);
      model_acc = in_clr_acc ? 0 : int'($signed(8'(r)));
      accepted++;
    end
  end

  logic       hold_v = 1'b0;
  logic [7:0] hold_d, hold_a, hold_b;
  always @(negedge clk) begin
    exp_t e;
    if (rst || !res_valid) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("res_data_stable", res_data, hold_d);
        chk("alu_op_a_stable", alu_op_a, hold_a);
        chk("alu_op_b_stable", alu_op_b, hold_b);
      end
      if (res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("res_data", res_data, e.res);
          chk("alu_opc", alu_opc, e.opc);
          chk("alu_op_a", alu_op_a, e.a);
          chk("alu_op_b", alu_op_b, e.b);
          got_q.push_back(res_data);
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = res_data;
        hold_a = alu_op_a;
        hold_b = alu_op_b;
      end
    end
  end

  initial begin
    rr_rand = 1'b1;
    forever begin
      @(posedge clk);
      #1 rr_rand = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic ua, input logic ca);
    logic ok;
    ok = 1'b0;
    in_opc = o; in_op_a = a; in_op_b = b; in_use_acc = ua; in_clr_acc = ca;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    chk("send_accepted", ok, 1'b1);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !res_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_complete", done, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string nm, input logic [7:0] req);
    logic [7:0] v;
    v = 8'hxx;
    if (got_q.size() != 0) v = got_q.pop_front();
    chk(nm, v, req);
  endtask

  initial begin
    int   t0;
    int   acc0;
    logic ok;
    rst = 1'b1; in_valid = 1'b0; in_opc = '0; in_op_a = '0; in_op_b = '0;
    in_use_acc = 1'b0; in_clr_acc = 1'b0; rr_main = 1'b0; rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_alu_op_a", alu_op_a, 8'd0);
    chk("rst_res_data", res_data, 8'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Single instruction and latency
    rr_main = 1'b1;
    t0 = cyc;
    send(3'd0, 8'd10, 8'hFB, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    chk("latency", 32'(cyc - t0), 32'd4);
    drain();
    chk_got("single_add", 8'd5);

    // Accumulator chain
    send(3'd0, 8'd10, 8'hFB, 1'b0, 1'b0);
    send(3'd0, 8'd99, 8'd3, 1'b1, 1'b0);
    send(3'd1, 8'd99, 8'd1, 1'b1, 1'b1);
    send(3'd0, 8'd99, 8'd7, 1'b1, 1'b0);
    drain();
    chk_got("chain0", 8'd5);
    chk_got("chain1", 8'd8);
    chk_got("chain2", 8'd7);
    chk_got("chain3", 8'd7);

    // Overflow pass-through
    send(3'd0, 8'd127, 8'd127, 1'b0, 1'b0);
    drain();
    chk_got("overflow", 8'hFE);

    // Backpressure: one held in DONE plus a full FIFO
    rr_main = 1'b0;
    send(3'd1, 8'd40, 8'd2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    acc0 = accepted;
    for (int k = 0; k < 5; k++) begin
      in_opc = 3'($urandom_range(0, 4)); in_op_a = 8'($urandom); in_op_b = 8'($urandom);
      in_use_acc = 1'($urandom_range(0, 1)); in_clr_acc = 1'b0; in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        if (ok) break;
      end
    end
    chk("bp_accepted", 32'(accepted - acc0), 32'd4);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_res_valid", res_valid, 1'b1);
    // Full FIFO with a pop this cycle: push must still be refused
    rr_main = 1'b1;
    @(negedge clk);
    chk("full_pop_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("after_pop_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_accepted_5th", 32'(accepted - acc0), 32'd5);
    drain();

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(3'($urandom_range(0, 5)), 8'($urandom), 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    rand_rdy = 1'b0;
    rr_main = 1'b1;
    drain();

    // Reset during WAIT with two entries buffered
    rr_main = 1'b0;
    send(3'd0, 8'd50, 8'd3, 1'b0, 1'b0);
    send(3'd0, 8'd60, 8'd4, 1'b0, 1'b0);
    send(3'd0, 8'd70, 8'd5, 1'b0, 1'b0);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    exp_q.delete();
    got_q.delete();
    model_acc = 0;
    chk("mid_rst_res_valid", res_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_alu_opc", alu_opc, 3'd0);
    chk("mid_rst_alu_op_a", alu_op_a, 8'd0);
    chk("mid_rst_alu_op_b", alu_op_b, 8'd0);
    chk("mid_rst_res_data", res_data, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rr_main = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_stale_res_valid", res_valid, 1'b0);
    chk("no_stale_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    send(3'd0, 8'd77, 8'd9, 1'b1, 1'b0);
    drain();
    chk_got("post_rst_acc_zero", 8'd9);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Instruction sequencer that sits in front of the shared combinational ALU.
- Buffers incoming instructions (opcode, op_a, op_b, flags) in a small FIFO and issues them one at a time to the ALU.
- Waits a fixed ALU settle time, captures the result and presents it on a valid/ready output.
- Keeps an accumulator so chained operations can use the previous result as op_a.

Parameters:
- DATA_W, 8, signed operand/result width (two's complement).
- OPC_W, 3, opcode width; opcode is passed to the ALU unmodified.
- DEPTH, 4, instruction FIFO depth (power of two, >=2).
- ALU_LAT, 1, cycles between driving ALU inputs and sampling alu_result (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  FIFO can accept (= not full).
- in_opc  in  OPC_W  opcode.
- in_op_a  in  DATA_W  operand A.
- in_op_b  in  DATA_W  operand B.
- in_use_acc  in  1  replace op_a with accumulator at issue.
- in_clr_acc  in  1  clear accumulator when this instruction's result is accepted (result itself still delivered).
- alu_opc  out  OPC_W  registered opcode to ALU.
- alu_op_a  out  DATA_W  registered operand A to ALU.
- alu_op_b  out  DATA_W  registered operand B to ALU.
- alu_result  in  DATA_W  combinational ALU output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  DATA_W  captured result.
- busy  out  1  state != IDLE or FIFO not empty.

Behaviour:
- Reset (async, any time, including mid-operation):
  - FIFO empty, accumulator 0, state IDLE.
  - alu_opc/alu_op_a/alu_op_b = 0, res_valid = 0, res_data = 0, busy = 0.
  - in_ready = 1 as soon as reset deasserts.
  - In-flight instruction and buffered entries are discarded.
- FIFO:
  - Push when in_valid && in_ready; in_ready = !full from the registered count.
  - A push offered while full is rejected even if a pop occurs in the same cycle.
  - Push on empty while IDLE: entry is visible to the FSM the next cycle, not the same cycle.
  - Simultaneous push and pop with count between 0 and DEPTH: count unchanged.
  - Pointers wrap modulo DEPTH.
- States:
  - IDLE: if FIFO not empty, pop head and go to ISSUE. Else stay.
  - ISSUE (1 cycle): register head into alu_* outputs; alu_op_a = acc if use_acc else op_a. Load wait counter with ALU_LAT-1 and go to WAIT.
  - WAIT: decrement counter. At 0, sample alu_result into res_data, set res_valid = 1, go to DONE.
  - DONE: hold res_valid/res_data stable until res_ready. On the handshake cycle:
    - res_valid drops next cycle.
    - acc <= 0 if clr_acc, else acc <= res_data.
    - If FIFO not empty, pop and go to ISSUE; else go to IDLE.
- Latency: with ALU_LAT=1 and FIFO empty in IDLE, in_valid at cycle t gives res_valid at t+4 (push, pop, issue, wait). Back-to-back throughput is one result per ALU_LAT+2 cycles when res_ready is held high.
- alu_* outputs hold the last issued values between instructions; they never change during WAIT or DONE.
- Arithmetic: the block does no arithmetic. Results are stored as the ALU returns them, with no saturation; overflow is the ALU's concern.
- res_ready asserted while res_valid = 0 is ignored.
- use_acc on the first instruction after reset uses acc = 0.

Test Plan:
- Single instruction: bench ALU stub has opc 0 = add, 1 = sub. Send {opc 0, a 10, b -5}, res_ready = 1. Expect res_valid at t+4, res_data = 5, alu_op_a = 10, alu_op_b = -5 stable from ISSUE through DONE.
- Accumulate chain: send {add 10,-5}, {add use_acc, b 3}, {sub use_acc, b 1, clr_acc}, {add use_acc, b 7}. Expect results 5, 8, 7, 7; accumulator is 0 before the fourth instruction.
- Overflow pass-through: send {add 127,127}. Expect res_data = -2 exactly as the ALU returns it.
- Backpressure: hold res_ready = 0, push 5 instructions. Expect 4 accepted, then in_ready = 0 and the 5th held. res_data stays stable while res_valid is high. Release res_ready: results are drained in order and the 5th is accepted once space frees.
- Full-plus-pop corner: with the FIFO full, assert in_valid in the same cycle as a pop. Expect the push to be rejected that cycle and accepted the next cycle.
- Reset mid-operation: assert rst during WAIT with 2 entries buffered. Expect all outputs 0, busy = 0, in_ready = 1 immediately. No stale result appears after rst deasserts. A new instruction then completes normally with acc = 0.
